// File: rtl/memory_dp_be.sv
// Simple dual-port RAM: one write port with byte-lane enables, one read port.
// It has selectable read-during-write behaviour, an optional output register and a post-reset clear sweep.
module memory_dp_be #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    BYTE_WIDTH   = 8,
    parameter int                    MAX_ADDR     = 16,
    parameter int                    ADDRSIZE     = $clog2(MAX_ADDR),
    parameter int                    RDW_MODE     = 0,
    parameter int                    OUT_REG      = 0,
    parameter int                    CLEAR_ON_RST = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE  = '0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             rd_en,
    input  logic [ADDRSIZE-1:0]              rd_addr,
    input  logic                             wr_en,
    input  logic [ADDRSIZE-1:0]              wr_addr,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_be,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    output logic [DATA_WIDTH-1:0]            rd_data,
    output logic                             rd_valid,
    output logic                             init_busy
);
    localparam int                  NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam logic [ADDRSIZE:0]   DEPTH = (ADDRSIZE+1)'(MAX_ADDR);
    localparam logic [ADDRSIZE-1:0] LAST  = ADDRSIZE'(MAX_ADDR - 1);

    typedef enum logic {S_CLEAR, S_READY} state_t;

    logic [DATA_WIDTH-1:0] r_mem [MAX_ADDR];
    state_t                r_state;
    logic [ADDRSIZE-1:0]   r_clr_addr;
    logic                  r_init_busy;
    logic                  r_s1_vld;
    logic [DATA_WIDTH-1:0] r_s1_dat;

    logic                  w_busy;
    logic                  w_wr_in;
    logic                  w_rd_in;
    logic                  w_wr_do;
    logic                  w_rd_do;
    logic [ADDRSIZE-1:0]   w_mem_addr;
    logic [NB-1:0]         w_mem_be;
    logic [DATA_WIDTH-1:0] w_mem_din;
    logic [DATA_WIDTH-1:0] w_rd_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= (CLEAR_ON_RST != 0) ? S_CLEAR : S_READY;
            r_init_busy <= (CLEAR_ON_RST != 0);
            r_clr_addr  <= '0;
        end else if (r_state == S_CLEAR) begin
            r_clr_addr <= r_clr_addr + ADDRSIZE'(1);
            if (r_clr_addr == LAST) begin
                r_state     <= S_READY;
                r_init_busy <= 1'b0;
                r_clr_addr  <= '0;
            end
        end
    end

    assign w_busy  = (r_state == S_CLEAR);
    assign w_wr_in = ({1'b0, wr_addr} < DEPTH);
    assign w_rd_in = ({1'b0, rd_addr} < DEPTH);
    assign w_wr_do = !rst && (w_busy || (wr_en && w_wr_in));
    assign w_rd_do = !rst && !w_busy && rd_en;

    // The clear sweep borrows the write port while it runs.
    assign w_mem_addr = w_busy ? r_clr_addr  : wr_addr;
    assign w_mem_be   = w_busy ? {NB{1'b1}}  : wr_be;
    assign w_mem_din  = w_busy ? CLEAR_VALUE : wr_data;

    always_ff @(posedge clk) begin
        if (w_wr_do) begin
            for (int i = 0; i < NB; i++) begin
                if (w_mem_be[i])
                    r_mem[w_mem_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= w_mem_din[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    always_comb begin
        w_rd_word = '0;
        if (w_rd_in) begin
            w_rd_word = r_mem[rd_addr];
            if (RDW_MODE != 0 && wr_en && wr_addr == rd_addr) begin
                for (int i = 0; i < NB; i++) begin
                    if (wr_be[i])
                        w_rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld <= 1'b0;
            r_s1_dat <= '0;
        end else begin
            r_s1_vld <= w_rd_do;
            if (w_rd_do)
                r_s1_dat <= w_rd_word;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic                  r_s2_vld;
            logic [DATA_WIDTH-1:0] r_s2_dat;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_s2_vld <= 1'b0;
                    r_s2_dat <= '0;
                end else begin
                    r_s2_vld <= r_s1_vld;
                    if (r_s1_vld)
                        r_s2_dat <= r_s1_dat;
                end
            end
            assign rd_data  = r_s2_dat;
            assign rd_valid = r_s2_vld;
        end else begin : g_no_out_reg
            assign rd_data  = r_s1_dat;
            assign rd_valid = r_s1_vld;
        end
    endgenerate

    assign init_busy = r_init_busy;
endmodule

// File: tb/tb_memory_dp_be.sv
// Three memory_dp_be variants share one stimulus stream.
// Each variant is checked every cycle against its own behavioural model and at fixed points against hand-computed values.
module tb_memory_dp_be;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  rd_addr = '0;
    logic [3:0]  wr_addr = '0;
    logic [3:0]  wr_be = '0;
    logic [31:0] wr_data = '0;

    logic [31:0] dut_dat  [3];
    logic        dut_vld  [3];
    logic        dut_busy [3];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // A: defaults. B: write-first with output register. C: depth 10, fill 0xFF.
    memory_dp_be u_a (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_be(wr_be), .wr_data(wr_data), .rd_data(dut_dat[0]), .rd_valid(dut_vld[0]), .init_busy(dut_busy[0]));
    memory_dp_be #(.RDW_MODE(1), .OUT_REG(1)) u_b (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_be(wr_be), .wr_data(wr_data), .rd_data(dut_dat[1]), .rd_valid(dut_vld[1]), .init_busy(dut_busy[1]));
    memory_dp_be #(.MAX_ADDR(10), .CLEAR_VALUE(32'h0000_00FF)) u_c (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_be(wr_be), .wr_data(wr_data), .rd_data(dut_dat[2]), .rd_valid(dut_vld[2]), .init_busy(dut_busy[2]));

    int          p_n    [3] = '{16, 16, 10};
    int          p_rdw  [3] = '{0, 1, 0};
    int          p_oreg [3] = '{0, 1, 0};
    logic [31:0] p_cv   [3] = '{32'h0, 32'h0, 32'hFF};

    logic [31:0] m_mem   [3][16];
    bit          m_known [3] = '{0, 0, 0};
    bit          m_busy  [3];
    int          m_cnt   [3];
    bit          m_p1v   [3];
    logic [31:0] m_p1d   [3];
    bit          m_ov    [3];
    logic [31:0] m_od    [3];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        for (int b = 0; b < 4; b++)
            if (be[b]) old[b*8 +: 8] = nw[b*8 +: 8];
        return old;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            logic [31:0] rv;
            if (rst) begin
                m_known[i] = 1;
                m_busy[i]  = 1;
                m_cnt[i]   = 0;
                m_p1v[i]   = 0;
                m_p1d[i]   = '0;
                m_ov[i]    = 0;
                m_od[i]    = '0;
            end else if (m_busy[i]) begin
                m_mem[i][m_cnt[i]] = p_cv[i];
                m_cnt[i]++;
                if (m_cnt[i] == p_n[i]) m_busy[i] = 0;
                m_ov[i] = 0;
            end else begin
                rv = '0;
                if (rd_en && int'(rd_addr) < p_n[i]) begin
                    rv = m_mem[i][rd_addr];
                    if (p_rdw[i] == 1 && wr_en && wr_addr == rd_addr) rv = merge(rv, wr_data, wr_be);
                end
                if (wr_en && int'(wr_addr) < p_n[i])
                    m_mem[i][wr_addr] = merge(m_mem[i][wr_addr], wr_data, wr_be);
                if (p_oreg[i] == 1) begin
                    m_ov[i] = m_p1v[i];
                    if (m_p1v[i]) m_od[i] = m_p1d[i];
                    m_p1v[i] = rd_en;
                    if (rd_en) m_p1d[i] = rv;
                end else begin
                    m_ov[i] = rd_en;
                    if (rd_en) m_od[i] = rv;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (m_known[i]) begin
                chk($sformatf("model_busy[%0d]", i), 32'(dut_busy[i]), 32'(m_busy[i]));
                chk($sformatf("model_vld[%0d]", i), 32'(dut_vld[i]), 32'(m_ov[i]));
                chk($sformatf("model_dat[%0d]", i), dut_dat[i], m_od[i]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_en = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic setrd(input int a);
        rd_en   = 1'b1;
        rd_addr = 4'(a);
    endtask

    task automatic setwr(input int a, input logic [31:0] d, input logic [3:0] be);
        wr_en   = 1'b1;
        wr_addr = 4'(a);
        wr_data = d;
        wr_be   = be;
    endtask

    initial begin
        int          nb [3];
        int          nv [3];
        bit          bv [5];
        logic [31:0] bd [5];

        // Reset values and clear sweep length
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_busy_a", 32'(dut_busy[0]), 32'd1);
        chk("rst_vld_a", 32'(dut_vld[0]), 32'd0);
        chk("rst_dat_a", dut_dat[0], 32'h0);
        nb = '{0, 0, 0};
        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < 3; i++) if (dut_busy[i]) nb[i]++;
            step();
        end
        chk("busy_len_a", 32'(nb[0]), 32'd16);
        chk("busy_len_b", 32'(nb[1]), 32'd16);
        chk("busy_len_c", 32'(nb[2]), 32'd10);

        // Back-to-back reads of the whole array
        nv = '{0, 0, 0};
        for (int k = 0; k < 18; k++) begin
            if (k < 16) setrd(k); else idle();
            step();
            for (int i = 0; i < 3; i++) if (dut_vld[i]) nv[i]++;
        end
        chk("sweep_vld_a", 32'(nv[0]), 32'd16);
        chk("sweep_vld_b", 32'(nv[1]), 32'd16);
        chk("sweep_vld_c", 32'(nv[2]), 32'd16);

        // Byte-lane merge
        setwr(3, 32'hDEADBEEF, 4'b1111);
        step();
        setwr(3, 32'h11223344, 4'b0101);
        step();
        idle();
        setrd(3);
        step();
        idle();
        chk("be_merge_a", dut_dat[0], 32'hDE22BE44);
        chk("be_merge_vld_a", 32'(dut_vld[0]), 32'd1);
        step();
        chk("be_merge_b", dut_dat[1], 32'hDE22BE44);

        // Read-during-write collision
        setwr(7, 32'hA5A5A5A5, 4'b1111);
        setrd(7);
        step();
        idle();
        chk("rdw_old_a", dut_dat[0], 32'h0);
        step();
        chk("rdw_new_b", dut_dat[1], 32'hA5A5A5A5);
        setrd(7);
        step();
        idle();
        chk("rdw_after_a", dut_dat[0], 32'hA5A5A5A5);
        step();
        chk("rdw_after_b", dut_dat[1], 32'hA5A5A5A5);

        // Output-register latency with consecutive reads
        for (int k = 0; k < 3; k++) begin
            setwr(k, 32'(32'h11111111 * (k + 1)), 4'b1111);
            step();
        end
        idle();
        step();
        for (int k = 0; k < 5; k++) begin
            if (k < 3) setrd(k); else idle();
            step();
            bv[k] = dut_vld[1];
            bd[k] = dut_dat[1];
        end
        chk("oreg_vld0", 32'(bv[0]), 32'd0);
        chk("oreg_vld1", 32'(bv[1]), 32'd1);
        chk("oreg_dat1", bd[1], 32'h11111111);
        chk("oreg_vld2", 32'(bv[2]), 32'd1);
        chk("oreg_dat2", bd[2], 32'h22222222);
        chk("oreg_vld3", 32'(bv[3]), 32'd1);
        chk("oreg_dat3", bd[3], 32'h33333333);
        chk("oreg_vld4", 32'(bv[4]), 32'd0);

        // Reset reasserted mid-clear, requests while busy
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        nb = '{0, 0, 0};
        nv = '{0, 0, 0};
        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < 3; i++) begin
                if (dut_busy[i]) nb[i]++;
                if (dut_vld[i]) nv[i]++;
            end
            if (k < 8) begin
                setwr(2, 32'h12345678, 4'b1111);
                setrd(2);
            end else begin
                idle();
            end
            step();
        end
        chk("restart_busy_len_c", 32'(nb[2]), 32'd10);
        chk("busy_no_vld_c", 32'(nv[2]), 32'd0);
        chk("busy_no_vld_a", 32'(nv[0]), 32'd0);

        // Out-of-range access on the depth-10 variant
        setwr(12, 32'hCAFEBABE, 4'b1111);
        step();
        idle();
        setrd(12);
        step();
        idle();
        chk("oor_dat_c", dut_dat[2], 32'h0);
        chk("oor_vld_c", 32'(dut_vld[2]), 32'd1);
        chk("inrange12_a", dut_dat[0], 32'hCAFEBABE);
        setrd(2);
        step();
        idle();
        chk("addr2_kept_c", dut_dat[2], 32'h000000FF);

        // Reset flushes an in-flight read
        setrd(0);
        step();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("flush_vld_b", 32'(dut_vld[1]), 32'd0);
        chk("flush_dat_b", dut_dat[1], 32'h0);
        step();
        chk("flush_vld_b_next", 32'(dut_vld[1]), 32'd0);
        for (int k = 0; k < 18; k++) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1);
    end
endmodule

// File: doc/memory_dp_be.md
Name: memory_dp_be

Overview:
Parametrised simple dual-port synchronous RAM: one write port, one read port, single clock domain. Generational successor to the basic dual-port memory. Adds per-byte write enables, selectable read-during-write behaviour, an optional output register, a read-valid strobe and a post-reset clear sequencer. Serves as the storage primitive for FIFOs, line buffers and register files in the datapath.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of BYTE_WIDTH.
BYTE_WIDTH, 8, bits per write-enable lane.
MAX_ADDR, 16, number of words; need not be a power of two.
ADDRSIZE, $clog2(MAX_ADDR), address port width; derived, not overridden.
RDW_MODE, 0, same-address read/write collision: 0 = read-first (old data), 1 = write-first (new data).
OUT_REG, 0, 1 adds an output pipeline register; read latency is 1+OUT_REG.
CLEAR_ON_RST, 1, 1 = clear all words to CLEAR_VALUE after reset.
CLEAR_VALUE, 0, DATA_WIDTH-bit fill value used by the clear sequencer.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
rd_en  input  1  read request, sampled at posedge
rd_addr  input  ADDRSIZE  read address
wr_en  input  1  write request, sampled at posedge
wr_addr  input  ADDRSIZE  write address
wr_be  input  DATA_WIDTH/BYTE_WIDTH  byte-lane write enables; bit i covers wr_data[i*BYTE_WIDTH +: BYTE_WIDTH]
wr_data  input  DATA_WIDTH  write data
rd_data  output  DATA_WIDTH  read data
rd_valid  output  1  one-cycle strobe, aligned with new rd_data
init_busy  output  1  high while the clear sequence runs; requests are ignored

Behaviour:
- Reset (rst=1 at posedge): rd_data=0, rd_valid=0, output pipeline stage cleared. init_busy=CLEAR_ON_RST. Clear address counter=0. Array contents are not reset directly.
- Clear FSM, two states: CLEAR and READY.
  - rst forces CLEAR if CLEAR_ON_RST=1, otherwise READY.
  - In CLEAR: each cycle after rst deasserts, writes CLEAR_VALUE to the counter address and increments the counter. After writing address MAX_ADDR-1, moves to READY.
  - Clear takes exactly MAX_ADDR cycles after the first cycle with rst=0. init_busy falls on the edge entering READY.
  - rst asserted mid-clear restarts the sweep from address 0.
- While init_busy=1: rd_en and wr_en are ignored, rd_valid stays 0, rd_data holds 0.
- Write (READY, wr_en=1): for each lane i with wr_be[i]=1, mem[wr_addr] lane i <= wr_data lane i. Other lanes are unchanged. wr_be all zero leaves the word unchanged.
- Read (READY, rd_en=1):
  - OUT_REG=0: rd_data is updated from mem[rd_addr] at the same edge; rd_valid=1 for the following cycle.
  - OUT_REG=1: data and rd_valid are delayed one further cycle.
  - With no read, rd_data holds its last value and rd_valid=0.
  - Back-to-back reads give one rd_valid per cycle with no bubbles.
- Collision (rd_en & wr_en & rd_addr==wr_addr):
  - RDW_MODE=0: returns the pre-write word.
  - RDW_MODE=1: returns the merged word, with enabled lanes taking wr_data and disabled lanes taking old data.
- Address >= MAX_ADDR (non-power-of-two depth): write is dropped; read returns 0 with rd_valid still asserted.
- rst asserted with a read in flight: the pipeline is flushed and no rd_valid is emitted for that read.

Test Plan:
1. Defaults, rst pulse 1 cycle -> init_busy=1 for exactly 16 cycles; reads of addresses 0..15 afterwards return 0x00000000 with one rd_valid each.
2. Write 0xDEADBEEF to addr 3 with wr_be=4'b1111, then wr_be=4'b0101 with 0x11223344 -> read addr 3 returns 0xDE22BE44.
3. Same-cycle write 0xA5A5A5A5 and read of addr 7, which holds 0x0 -> RDW_MODE=0 returns 0x00000000; RDW_MODE=1 returns 0xA5A5A5A5; a following read returns 0xA5A5A5A5 in both modes.
4. OUT_REG=1, reads of addr 0,1,2 on consecutive cycles -> rd_valid high on cycles 2,3,4 after the first request, with the data in order.
5. MAX_ADDR=10, CLEAR_VALUE=0xFF, rst reasserted at clear cycle 5 -> sweep restarts, init_busy lasts 10 cycles after the final rst; writes and reads issued while busy have no effect and produce no rd_valid.
6. MAX_ADDR=10: write to addr 12 then read addr 12 -> read returns 0 with rd_valid=1; addr 2 is unchanged.
